hold_mon: RTL and testbench

Downstream checker for the hold-output FSM stage. It samples that stage's state-held toggle `f` and transit-held window `g`. For every `g` high window it measures the window length and counts the `f` toggles inside it. Each completed window becomes one report record, offered on a valid/ready port to the status collector.

---
 rtl/hold_pkg.sv | 21 ++
 rtl/hold_mon_if.sv | 32 +++
 rtl/hold_edge.sv | 32 +++
 rtl/hold_mon.sv | 139 +++++++++++++
 tb/tb_hold_mon.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/hold_pkg.sv
// Shared types and constants for the hold-output window monitor.
package hold_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StMeas   = 2'd1,
        StReport = 2'd2
    } hold_mon_state_t;

    // Width of the saturating toggle count carried in a report.
    localparam int unsigned TogW = 2;

    localparam int unsigned DefMinLen = 2;
    localparam int unsigned DefMaxLen = 200;

    // Saturating increment of a toggle count.
    function automatic logic [TogW-1:0] tog_sat_inc(input logic [TogW-1:0] v);
        return (v == {TogW{1'b1}}) ? v : v + TogW'(1);
    endfunction

endpackage

// File: rtl/hold_mon_if.sv
// Report record port: valid/ready handshake plus the record fields.
interface hold_mon_if
    import hold_pkg::*;
#(
    parameter int unsigned LEN_W = 8
) ();

    logic             rpt_valid;
    logic             rpt_ready;
    logic [LEN_W-1:0] rpt_len;
    logic [TogW-1:0]  rpt_tog;
    logic             rpt_err;

    // Monitor side: offers records.
    modport master (
        output rpt_valid,
        output rpt_len,
        output rpt_tog,
        output rpt_err,
        input  rpt_ready
    );

    // Collector side: accepts records.
    modport slave (
        input  rpt_valid,
        input  rpt_len,
        input  rpt_tog,
        input  rpt_err,
        output rpt_ready
    );

endinterface

// File: rtl/hold_edge.sv
// Input edge detection: window rise and toggle-change strobes.
module hold_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic f_i,
    input  logic g_i,
    output logic g_rise,
    output logic f_tog
);

    logic g_q;
    logic f_q;

    // One-cycle delayed input copies; g_q resets high so a window already
    // open at reset release never produces a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_q <= 1'b1;
            f_q <= 1'b0;
        end else begin
            g_q <= g_i;
            f_q <= f_i;
        end
    end

    // Strobes derived from current input versus delayed copy.
    always_comb begin
        g_rise = g_i & ~g_q;
        f_tog  = f_i ^ f_q;
    end

endmodule

// File: rtl/hold_mon.sv
// Window monitor: measures each g window, counts f toggles inside it and
// offers one report record per completed window.
module hold_mon
    import hold_pkg::*;
#(
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned MIN_LEN = DefMinLen,
    parameter int unsigned MAX_LEN = DefMaxLen
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       f_i,
    input  logic       g_i,
    hold_mon_if.master rpt,
    output logic       drop,
    output logic       busy
);

    localparam logic [LEN_W-1:0] LenOne  = LEN_W'(1);
    localparam logic [LEN_W-1:0] LenMax  = {LEN_W{1'b1}};
    localparam logic [LEN_W-1:0] MinLenW = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MaxLenW = LEN_W'(MAX_LEN);
    localparam logic [TogW-1:0]  TogOne  = TogW'(1);

    logic g_rise;
    logic f_tog;

    hold_mon_state_t  state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [TogW-1:0]  tog_q, tog_d;
    logic             rpt_valid_q, rpt_valid_d;
    logic [LEN_W-1:0] rpt_len_q, rpt_len_d;
    logic [TogW-1:0]  rpt_tog_q, rpt_tog_d;
    logic             rpt_err_q, rpt_err_d;
    logic             drop_q, drop_d;

    logic [LEN_W-1:0] len_inc;
    logic [TogW-1:0]  tog_next;
    logic             handshake;

    hold_edge u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .f_i    (f_i),
        .g_i    (g_i),
        .g_rise (g_rise),
        .f_tog  (f_tog)
    );

    // Next state, counters and report record.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        tog_d       = tog_q;
        rpt_valid_d = rpt_valid_q;
        rpt_len_d   = rpt_len_q;
        rpt_tog_d   = rpt_tog_q;
        rpt_err_d   = rpt_err_q;
        drop_d      = drop_q;

        len_inc   = (len_q == LenMax) ? len_q : len_q + LenOne;
        tog_next  = f_tog ? tog_sat_inc(tog_q) : tog_q;
        handshake = rpt_valid_q & rpt.rpt_ready;

        case (state_q)
            StIdle: begin
                if (g_rise) begin
                    state_d = StMeas;
                    len_d   = LenOne;
                    tog_d   = '0;
                end
            end
            StMeas: begin
                tog_d = tog_next;
                if (g_i) begin
                    len_d = len_inc;
                end else begin
                    // Closing cycle: its toggle still belongs to this window.
                    state_d     = StReport;
                    rpt_valid_d = 1'b1;
                    rpt_len_d   = len_q;
                    rpt_tog_d   = tog_next;
                    rpt_err_d   = (len_q < MinLenW) || (len_q > MaxLenW) ||
                                  (tog_next != TogOne);
                end
            end
            StReport: begin
                if (handshake) begin
                    rpt_valid_d = 1'b0;
                    if (g_rise) begin
                        state_d = StMeas;
                        len_d   = LenOne;
                        tog_d   = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (g_rise) begin
                    // Window lost: it is never measured later.
                    drop_d = 1'b1;
                end
            end
            default: begin
                state_d     = StIdle;
                rpt_valid_d = 1'b0;
            end
        endcase
    end

    // State, counter and report registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            len_q       <= '0;
            tog_q       <= '0;
            rpt_valid_q <= 1'b0;
            rpt_len_q   <= '0;
            rpt_tog_q   <= '0;
            rpt_err_q   <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            tog_q       <= tog_d;
            rpt_valid_q <= rpt_valid_d;
            rpt_len_q   <= rpt_len_d;
            rpt_tog_q   <= rpt_tog_d;
            rpt_err_q   <= rpt_err_d;
            drop_q      <= drop_d;
        end
    end

    assign rpt.rpt_valid = rpt_valid_q;
    assign rpt.rpt_len   = rpt_len_q;
    assign rpt.rpt_tog   = rpt_tog_q;
    assign rpt.rpt_err   = rpt_err_q;
    assign drop          = drop_q;
    assign busy          = (state_q == StMeas);

endmodule

// File: tb/tb_hold_mon.sv
// Bench for hold_mon: a default-width instance and a LEN_W=4 instance share
// the same f/g/ready stimulus; expected records come from a window-level model.
module tb_hold_mon;

    logic clk = 1'b0;
    logic rst_n;
    logic f;
    logic g;
    logic rpt_ready;
    logic drop_b, busy_b, drop_s, busy_s;

    int checks = 0;
    int errors = 0;
    int nrep;

    always #5 clk = ~clk;

    hold_mon_if #(.LEN_W(8)) rb ();
    hold_mon_if #(.LEN_W(4)) rs ();

    assign rb.rpt_ready = rpt_ready;
    assign rs.rpt_ready = rpt_ready;

    hold_mon #(.LEN_W(8), .MIN_LEN(2), .MAX_LEN(200)) u_big (
        .clk   (clk),
        .rst_n (rst_n),
        .f_i   (f),
        .g_i   (g),
        .rpt   (rb),
        .drop  (drop_b),
        .busy  (busy_b)
    );

    hold_mon #(.LEN_W(4), .MIN_LEN(2), .MAX_LEN(12)) u_small (
        .clk   (clk),
        .rst_n (rst_n),
        .f_i   (f),
        .g_i   (g),
        .rpt   (rs),
        .drop  (drop_s),
        .busy  (busy_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Window model: len = high cycles; toggles counted on high cycles 2..len
    // and on the closing low cycle; both saturate; err from final values.
    task automatic model(input int len, input logic [31:0] mask, input int lenw,
                         input int maxl, output int el, output int et, output int ee);
        int t;
        int lim;
        t = 0;
        for (int k = 2; k <= len + 1; k++) if (mask[k]) t++;
        lim = (1 << lenw) - 1;
        el = (len > lim) ? lim : len;
        et = (t > 3) ? 3 : t;
        ee = (el < 2 || el > maxl || et != 1) ? 1 : 0;
    endtask

    // Drive one window: len high cycles, one low cycle, then gap-1 more low
    // cycles. mask bit k flips f before cycle k (k=1 is the rise cycle).
    task automatic frame(input string tag, input int len, input logic [31:0] mask,
                         input int gap, input bit expect_rpt);
        int bl, bt, be, sl, st, se;
        model(len, mask, 8, 200, bl, bt, be);
        model(len, mask, 4, 12, sl, st, se);
        for (int k = 1; k <= len + 1; k++) begin
            g = (k <= len);
            if (mask[k]) f = ~f;
            step();
            if (k == 1 && expect_rpt) chk({tag, ".busy"}, 32'(busy_b), 32'd1);
        end
        if (expect_rpt) begin
            chk({tag, ".valid"}, 32'(rb.rpt_valid), 32'd1);
            chk({tag, ".len"}, 32'(rb.rpt_len), 32'(bl));
            chk({tag, ".tog"}, 32'(rb.rpt_tog), 32'(bt));
            chk({tag, ".err"}, 32'(rb.rpt_err), 32'(be));
            chk({tag, ".s_len"}, 32'(rs.rpt_len), 32'(sl));
            chk({tag, ".s_tog"}, 32'(rs.rpt_tog), 32'(st));
            chk({tag, ".s_err"}, 32'(rs.rpt_err), 32'(se));
            if (rb.rpt_valid === 1'b1) nrep++;
        end
        for (int k = 1; k < gap; k++) begin
            g = 1'b0;
            step();
            if (k == 1 && expect_rpt && rpt_ready)
                chk({tag, ".valid_drop"}, 32'(rb.rpt_valid), 32'd0);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid"}, 32'(rb.rpt_valid), 32'd0);
        chk({tag, ".len"}, 32'(rb.rpt_len), 32'd0);
        chk({tag, ".tog"}, 32'(rb.rpt_tog), 32'd0);
        chk({tag, ".err"}, 32'(rb.rpt_err), 32'd0);
        chk({tag, ".drop"}, 32'(drop_b), 32'd0);
        chk({tag, ".busy"}, 32'(busy_b), 32'd0);
        chk({tag, ".s_valid"}, 32'(rs.rpt_valid), 32'd0);
        chk({tag, ".s_drop"}, 32'(drop_s), 32'd0);
    endtask

    initial begin
        logic [31:0] m;
        rst_n = 1'b0;
        f = 1'b0;
        g = 1'b0;
        rpt_ready = 1'b1;
        nrep = 0;
        step();
        step();
        chk_zero("reset");
        rst_n = 1'b1;
        step();

        // Nominal frame, then a low cycle to see the one-cycle pulse.
        frame("nominal", 6, 32'h40, 2, 1'b1);

        // Ten back-to-back 7-cycle frames.
        nrep = 0;
        for (int i = 0; i < 10; i++) frame("b2b", 6, 32'h40, 1, 1'b1);
        g = 1'b0;
        step();
        chk("b2b.count", 32'(nrep), 32'd10);
        chk("b2b.drop", 32'(drop_b), 32'd0);
        chk("b2b.valid_end", 32'(rb.rpt_valid), 32'd0);

        // Short and bad frames.
        frame("short", 1, 32'h4, 2, 1'b1);
        frame("notog", 6, 32'h0, 2, 1'b1);
        frame("twotog", 6, 32'h48, 2, 1'b1);
        frame("firsttog", 4, 32'h2 | 32'h20, 2, 1'b1);

        // Long window: saturates the 4-bit length, four toggles saturate at 3.
        frame("sat", 20, 32'h2a8, 2, 1'b1);

        // Random frames with ready held high.
        for (int i = 0; i < 24; i++) begin
            m = $urandom;
            frame("rand", int'($urandom_range(1, 20)), m, int'($urandom_range(1, 3)), 1'b1);
        end
        chk("rand.drop", 32'(drop_b), 32'd0);

        // Backpressure: second window arrives while the first is pending.
        rpt_ready = 1'b0;
        frame("bp_a", 6, 32'h40, 1, 1'b1);
        frame("bp_b", 5, 32'h20, 3, 1'b0);
        chk("bp.hold_valid", 32'(rb.rpt_valid), 32'd1);
        chk("bp.hold_len", 32'(rb.rpt_len), 32'd6);
        chk("bp.hold_tog", 32'(rb.rpt_tog), 32'd1);
        chk("bp.hold_err", 32'(rb.rpt_err), 32'd0);
        chk("bp.drop", 32'(drop_b), 32'd1);
        chk("bp.s_drop", 32'(drop_s), 32'd1);
        chk("bp.busy", 32'(busy_b), 32'd0);
        rpt_ready = 1'b1;
        step();
        chk("bp.release", 32'(rb.rpt_valid), 32'd0);
        frame("bp_c", 6, 32'h40, 2, 1'b1);
        chk("bp.drop_sticky", 32'(drop_b), 32'd1);

        // Reset mid-window clears everything at once.
        g = 1'b1;
        step();
        step();
        step();
        chk("rst.busy_before", 32'(busy_b), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_async");
        step();
        rst_n = 1'b1;
        // Window still open at release must be ignored.
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst.ignored_busy", 32'(busy_b), 32'd0);
        end
        g = 1'b0;
        step();
        step();
        chk("rst.ignored_valid", 32'(rb.rpt_valid), 32'd0);
        frame("rst_after", 6, 32'h40, 2, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
